grid_solve_ctrl: RTL

//  Sequencer between a host and one sudoku grid instance. On a host request it clears the grid,

---
 rtl/grid_pkg.sv | 26 ++
 rtl/onehot_to_bin.sv | 18 +
 rtl/grid_solve_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/grid_pkg.sv
// Shared types and widths for the sudoku grid solve controller.
// Grid dimensions normally arrive from grid_dimensions.svh; the 4x4 model grid is the fallback.
`ifndef GRID_LEN
`define GRID_LEN 4
`endif
`ifndef GRID_AREA
`define GRID_AREA 16
`endif

package grid_pkg;

    localparam int GRID_LEN   = `GRID_LEN;
    localparam int GRID_AREA  = `GRID_AREA;
    localparam int CELL_IDX_W = $clog2(GRID_AREA);
    localparam int CELL_VAL_W = $clog2(GRID_LEN + 1);

    typedef enum logic [5:0] {
        IDLE   = 6'b000001,
        CLEAR  = 6'b000010,
        START  = 6'b000100,
        SOLVE  = 6'b001000,
        DUMP   = 6'b010000,
        REPORT = 6'b100000
    } ctrl_state_e;

endpackage

// File: rtl/onehot_to_bin.sv
// Converts a one-hot cell value to its binary digit (bit position + 1, 0 when empty).
// Several bits set resolve to the lowest one.
module onehot_to_bin
    import grid_pkg::*;
(
    input  logic [GRID_LEN-1:0]   i_onehot,
    output logic [CELL_VAL_W-1:0] o_bin
);

    // Scanning downwards lets the lowest set bit overwrite any higher one.
    always_comb begin
        o_bin = '0;
        for (int i = GRID_LEN - 1; i >= 0; i--) begin
            if (i_onehot[i]) o_bin = CELL_VAL_W'(i + 1);
        end
    end

endmodule

// File: rtl/grid_solve_ctrl.sv
// Host-side sequencer for one sudoku grid: clear, start, watch for done, stream the
// solved cells out row-major over valid/ready, then pulse a one-cycle status report.
module grid_solve_ctrl
    import grid_pkg::*;
#(
    parameter int CLEAR_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 1 << 20
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rq_solve,
    input  logic                  abort,
    output logic                  busy,
    output logic                  grid_reset,
    output logic                  grid_start,
    input  logic                  grid_done,
    input  logic                  grid_success,
    output logic [CELL_IDX_W-1:0] rd_idx,
    input  logic [GRID_LEN-1:0]   rd_value,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CELL_VAL_W-1:0] out_value,
    output logic                  out_last,
    output logic                  rpt_valid,
    output logic                  rpt_success,
    output logic                  rpt_timeout,
    output logic                  rpt_aborted
);

    localparam int CLR_W = $clog2(CLEAR_CYCLES + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CLR_W-1:0]      CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);
    localparam logic [WD_W-1:0]       WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CELL_IDX_W-1:0] IDX_LAST = CELL_IDX_W'(GRID_AREA - 1);

    ctrl_state_e             r_state;
    ctrl_state_e             w_nextState;
    logic [CLR_W-1:0]        r_clrCnt;
    logic [WD_W-1:0]         r_wdog;
    logic [CELL_IDX_W-1:0]   r_rdIdx;
    logic                    r_outValid;
    logic                    r_outLast;
    logic                    r_allLoaded;
    logic [CELL_VAL_W-1:0]   r_outValue;
    logic [CELL_VAL_W-1:0]   w_encValue;
    logic                    r_rptSuccess;
    logic                    r_rptTimeout;
    logic                    r_rptAborted;
    logic                    w_setSuccess;
    logic                    w_setTimeout;
    logic                    w_setAborted;
    logic                    w_load;
    logic                    w_lastBeat;

    onehot_to_bin u_enc (
        .i_onehot (rd_value),
        .o_bin    (w_encValue)
    );

    assign w_load     = (r_state == DUMP) && !r_allLoaded && (!r_outValid || out_ready);
    assign w_lastBeat = r_outValid && out_ready && r_outLast;

    always_comb begin
        w_nextState  = r_state;
        w_setSuccess = 1'b0;
        w_setTimeout = 1'b0;
        w_setAborted = 1'b0;
        busy         = 1'b1;
        grid_reset   = 1'b0;
        grid_start   = 1'b0;
        rpt_valid    = 1'b0;
        unique case (r_state)
            IDLE: begin
                busy       = 1'b0;
                grid_reset = 1'b1;
                if (rq_solve) w_nextState = CLEAR;
            end
            CLEAR: begin
                grid_reset = 1'b1;
                if (abort) begin
                    w_nextState  = REPORT;
                    w_setAborted = 1'b1;
                end else if (r_clrCnt == CLR_LAST) begin
                    w_nextState = START;
                end
            end
            START: begin
                grid_start = 1'b1;
                if (abort) begin
                    w_nextState  = REPORT;
                    w_setAborted = 1'b1;
                end else begin
                    w_nextState = SOLVE;
                end
            end
            SOLVE: begin
                if (abort) begin
                    w_nextState  = REPORT;
                    w_setAborted = 1'b1;
                end else if (grid_done) begin
                    w_nextState = grid_success ? DUMP : REPORT;
                end else if (r_wdog == WD_LAST) begin
                    w_nextState  = REPORT;
                    w_setTimeout = 1'b1;
                end
            end
            DUMP: begin
                if (abort) begin
                    w_nextState  = REPORT;
                    w_setAborted = 1'b1;
                end else if (w_lastBeat) begin
                    w_nextState  = REPORT;
                    w_setSuccess = 1'b1;
                end
            end
            REPORT: begin
                grid_reset  = 1'b1;
                rpt_valid   = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                grid_reset  = 1'b1;
                w_nextState = IDLE;
            end
        endcase
    end

    // Result flags are captured on the edge that enters REPORT, so they are zero elsewhere.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_clrCnt     <= '0;
            r_wdog       <= '0;
            r_rdIdx      <= '0;
            r_outValid   <= 1'b0;
            r_outLast    <= 1'b0;
            r_outValue   <= '0;
            r_allLoaded  <= 1'b0;
            r_rptSuccess <= 1'b0;
            r_rptTimeout <= 1'b0;
            r_rptAborted <= 1'b0;
        end else begin
            r_state      <= w_nextState;
            r_rptSuccess <= w_setSuccess;
            r_rptTimeout <= w_setTimeout;
            r_rptAborted <= w_setAborted;
            unique case (r_state)
                IDLE:  r_clrCnt <= '0;
                CLEAR: r_clrCnt <= r_clrCnt + CLR_W'(1);
                START: r_wdog   <= '0;
                SOLVE: begin
                    r_wdog      <= r_wdog + WD_W'(1);
                    r_rdIdx     <= '0;
                    r_allLoaded <= 1'b0;
                end
                default: ;
            endcase
            if (w_load) begin
                r_outValid <= 1'b1;
                r_outValue <= w_encValue;
                r_outLast  <= (r_rdIdx == IDX_LAST);
                if (r_rdIdx == IDX_LAST) r_allLoaded <= 1'b1;
                else                     r_rdIdx     <= r_rdIdx + CELL_IDX_W'(1);
            end else if (r_outValid && out_ready) begin
                r_outValid <= 1'b0;
            end
            // Leaving DUMP (done or aborted) drops the stream without a trailing beat.
            if (w_nextState != DUMP) begin
                r_outValid <= 1'b0;
                r_outLast  <= 1'b0;
            end
        end
    end

    assign rd_idx      = r_rdIdx;
    assign out_valid   = r_outValid;
    assign out_value   = r_outValue;
    assign out_last    = r_outLast;
    assign rpt_success = r_rptSuccess;
    assign rpt_timeout = r_rptTimeout;
    assign rpt_aborted = r_rptAborted;

endmodule
